fifo_serial_tx: RTL and testbench

Downstream drain stage for the 16-bit FIFO. Pops one word whenever the FIFO is non-empty and the block is idle, then shifts the word out on a single UART-style line. The line format is LSB first: 1 start bit, 16 data bits, 1 stop bit. The block sits between the FIFO read side (EMPTY/RD/VALID/DOUT) and the board TX pin.

---
 rtl/fifo_serial_tx.sv | 212 +++++++++++++++++++++
 tb/tb_fifo_serial_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// -----------------------------------------------------------------------------
// fifo_serial_tx
//
// Drain stage for the 16-bit FIFO. When the block is idle and the FIFO reports
// data, it issues a single-cycle read and waits a bounded time for the read
// data. It then shifts the word out on a UART-style line:
//   start bit (0), 16 data bits LSB first, [even parity], stop bit (1).
// Each bit is held for CLKDIV clock cycles.
//
// Optional feature, selected with `define FIFO_SERIAL_TX_PARITY_EN:
//   a parity bit (XOR of the 16 data bits) is sent between the last data bit
//   and the stop bit. The frame grows from 18*CLKDIV to 19*CLKDIV cycles.
//
// Parameters
//   CLKDIV         clock cycles per serial bit, 2..65535
//   VALID_TIMEOUT  cycles after the RD pulse at which a missing VALID aborts
//                  the pop (ERR then pulses exactly this many cycles after RD)
//
// Ports
//   CLK    in   system clock, everything on posedge
//   RST    in   asynchronous active-low reset
//   EMPTY  in   FIFO empty flag
//   VALID  in   FIFO read data valid, one cycle after an accepted RD
//   DIN    in   FIFO read data (16 bits)
//   RD     out  FIFO read request, one-cycle pulse
//   TXD    out  serial line, idles high
//   BUSY   out  high from the pop request until the stop bit completes
//   ERR    out  one-cycle pulse when VALID did not arrive in time
//
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_serial_tx #(
  parameter int CLKDIV        = 868,
  parameter int VALID_TIMEOUT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EMPTY,
  input  logic        VALID,
  input  logic [15:0] DIN,
  output logic        RD,
  output logic        TXD,
  output logic        BUSY,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Terminal count of the baud counter: one bit period is 0..CLKDIV-1.
  localparam logic [15:0] BAUD_LAST = 16'(CLKDIV - 1);

  // The timeout is measured from the RD pulse. The REQ cycle is already one
  // cycle of that budget and WAIT samples VALID at the end of each of its
  // cycles, so the abort happens when the WAIT count reaches VALID_TIMEOUT-2.
  // Budgets shorter than two cycles collapse to a single VALID sample.
  localparam logic [15:0] WAIT_LAST = (VALID_TIMEOUT > 2) ? 16'(VALID_TIMEOUT - 2) : 16'd0;

  state_t      state;
  logic [15:0] baud_cnt;   // cycles spent in the current state / bit
  logic [3:0]  bit_cnt;    // data bit index 0..15
  logic [15:0] shreg;      // word being sent, bit 0 is always the next data bit

`ifdef FIFO_SERIAL_TX_PARITY_EN
  // Parity is captured when the word is latched because the shift register
  // no longer holds the full word by the time the parity bit is due.
  logic        parity_q;
`endif

  logic baud_last;
  assign baud_last = (baud_cnt == BAUD_LAST);

  // NOTE: a single clocked block owns the state and every output, so all of
  // them use non-blocking assignments; reading a register here always yields
  // its value from before this edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: the whole datapath is small and reset explicitly, including the
      // shift register, so an aborted frame leaves nothing stale behind.
      state    <= S_IDLE;
      RD       <= 1'b0;
      TXD      <= 1'b1;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // RD and ERR are single-cycle pulses: they fall back to 0 on every edge
      // unless the branch below raises them again.
      RD  <= 1'b0;
      ERR <= 1'b0;

      case (state)
        S_IDLE: begin
          TXD      <= 1'b1;
          baud_cnt <= '0;
          // EMPTY is only looked at here, so the FIFO is never read while it
          // reports empty and EMPTY activity during a frame has no effect.
          if (!EMPTY) begin
            state <= S_REQ;
            RD    <= 1'b1;
            BUSY  <= 1'b1;
          end
        end

        S_REQ: begin
          state    <= S_WAIT;
          baud_cnt <= '0;
        end

        S_WAIT: begin
          if (VALID) begin
            shreg    <= DIN;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_q <= ^DIN;
`endif
            state    <= S_START;
            TXD      <= 1'b0;
            baud_cnt <= '0;
          end else if (baud_cnt == WAIT_LAST) begin
            // Give up on this pop; the word is not retried.
            state    <= S_IDLE;
            ERR      <= 1'b1;
            BUSY     <= 1'b0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_START: begin
          if (baud_last) begin
            state    <= S_DATA;
            TXD      <= shreg[0];
            bit_cnt  <= '0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd15) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
              state <= S_PARITY;
              TXD   <= parity_q;
`else
              state <= S_STOP;
              TXD   <= 1'b1;
`endif
            end else begin
              // TXD is registered, so it is loaded with the bit that becomes
              // shreg[0] after this shift.
              shreg   <= {1'b0, shreg[15:1]};
              TXD     <= shreg[1];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

`ifdef FIFO_SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            state    <= S_STOP;
            TXD      <= 1'b1;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`endif

        S_STOP: begin
          if (baud_last) begin
            // BUSY drops on the same edge as the return to IDLE, so the next
            // pop can follow without any extra stop-bit stretch.
            state    <= S_IDLE;
            BUSY     <= 1'b0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          state    <= S_IDLE;
          TXD      <= 1'b1;
          BUSY     <= 1'b0;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_serial_tx
//
// Self-checking bench for fifo_serial_tx with CLKDIV=4, VALID_TIMEOUT=3.
// A small FIFO model (a queue) drives EMPTY/VALID/DIN. Every clock the
// observed {RD,BUSY,ERR,TXD} is compared against a reference computed from
// the frame description: for the k-th popped word, RD appears one cycle after
// the FIFO becomes non-empty plus k*(frame+3) cycles, the frame starts two
// cycles after RD, and each frame bit lasts CLKDIV cycles.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_serial_tx;

  localparam int CLKDIV = 4;
  localparam int VT     = 3;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int  NBITS     = 19;
  localparam bit  PARITY_ON = 1'b1;
`else
  localparam int  NBITS     = 18;
  localparam bit  PARITY_ON = 1'b0;
`endif
  localparam int F = NBITS * CLKDIV;

  logic        CLK;
  logic        RST;
  logic        EMPTY;
  logic        VALID;
  logic [15:0] DIN;
  logic        RD;
  logic        TXD;
  logic        BUSY;
  logic        ERR;

  fifo_serial_tx #(
    .CLKDIV        (CLKDIV),
    .VALID_TIMEOUT (VT)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EMPTY (EMPTY),
    .VALID (VALID),
    .DIN   (DIN),
    .RD    (RD),
    .TXD   (TXD),
    .BUSY  (BUSY),
    .ERR   (ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scenario description used by the reference model.
  int          c0;             // cycle at which the FIFO became non-empty
  int          n_words;        // words popped in this scenario
  logic [15:0] sc_words [4];
  bit          mute;           // FIFO never answers with VALID
  bit          checking;
  int          glitch_cyc;     // cycle with a stray VALID, -1 for none

  // FIFO model state.
  logic [15:0] fifo_q [$];
  bit          valid_pending;
  logic [15:0] valid_word;

  function automatic logic [3:0] obs_vec();
    return {RD, BUSY, ERR, TXD};
  endfunction

  // Line level of frame bit i for word w: start, data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [15:0] w, input int i);
    if (i == 0) return 1'b0;
    if (i <= 16) return w[i-1];
    if (PARITY_ON && i == 17) return ^w;
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_vec(input int t);
    logic rd, busy, err, txd;
    int   rd_c, st;
    rd = 1'b0; busy = 1'b0; err = 1'b0; txd = 1'b1;
    for (int k = 0; k < n_words; k++) begin
      rd_c = c0 + 1 + k * (F + 3);
      st   = rd_c + 2;
      if (t == rd_c) rd = 1'b1;
      if (mute) begin
        if (t >= rd_c && t < rd_c + VT) busy = 1'b1;
        if (t == rd_c + VT) err = 1'b1;
      end else begin
        if (t >= rd_c && t < st + F) busy = 1'b1;
        if (t >= st && t < st + F) txd = frame_bit(sc_words[k], (t - st) / CLKDIV);
      end
    end
    return {rd, busy, err, txd};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed(rd,busy,err,txd)=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, compare, then play the FIFO.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (checking) check("frame", obs_vec(), model_vec(cyc));
    VALID = 1'b0;
    if (valid_pending) begin
      VALID         = 1'b1;
      DIN           = valid_word;
      valid_pending = 1'b0;
    end else if (cyc == glitch_cyc) begin
      VALID = 1'b1;
      DIN   = 16'($urandom);
    end
    if (RD && RST && fifo_q.size() > 0) begin
      valid_word    = fifo_q.pop_front();
      valid_pending = !mute;
    end
    EMPTY = (fifo_q.size() == 0);
  endtask

  task automatic launch(input int n, input int npush);
    n_words = n;
    c0      = cyc;
    for (int i = 0; i < npush; i++) fifo_q.push_back(sc_words[i]);
    EMPTY    = (fifo_q.size() == 0);
    checking = 1'b1;
  endtask

  task automatic push_word(input logic [15:0] w);
    fifo_q.push_back(w);
    EMPTY = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    RST = 1'b0; EMPTY = 1'b1; VALID = 1'b0; DIN = '0;
    checking = 1'b0; n_words = 0; mute = 1'b0; glitch_cyc = -1;
    valid_pending = 1'b0; valid_word = '0; c0 = 0;

    // Reset state.
    run(3);
    check("reset_state", obs_vec(), 4'b0001);
    RST = 1'b1;

    // FIFO empty for 200 cycles: no RD, line idle.
    n_words = 0; c0 = cyc; checking = 1'b1;
    run(200);

    // Single word 16'hA5C3.
    sc_words[0] = 16'hA5C3;
    launch(1, 1);
    run(1 + (F + 3) + 8);

    // Back-to-back 16'h0001, 16'hFFFF, then idle.
    sc_words[0] = 16'h0001;
    sc_words[1] = 16'hFFFF;
    launch(2, 2);
    run(1 + 2 * (F + 3) + 20);

    // Random words; later words arrive mid-frame, a stray VALID hits DATA.
    for (int i = 0; i < 3; i++) sc_words[i] = 16'($urandom);
    launch(3, 1);
    glitch_cyc = c0 + 40;
    run(30);
    push_word(sc_words[1]);
    run(20);
    push_word(sc_words[2]);
    run(1 + 3 * (F + 3) + 10 - 50);
    glitch_cyc = -1;

    // VALID never arrives: one RD, ERR three cycles later, line stays high.
    mute = 1'b1;
    sc_words[0] = 16'($urandom);
    launch(1, 1);
    run(20);
    mute = 1'b0;

    // Reset in the middle of DATA.
    sc_words[0] = 16'($urandom);
    launch(1, 1);
    run(20);
    checking = 1'b0;
    #2 RST = 1'b0;
    #1 check("reset_mid_async", obs_vec(), 4'b0001);
    repeat (5) begin
      tick();
      check("reset_mid_hold", obs_vec(), 4'b0001);
    end
    valid_pending = 1'b0;
    RST = 1'b1;
    n_words = 0; c0 = cyc; checking = 1'b1;
    run(30);

    // Normal frame after recovery.
    sc_words[0] = 16'($urandom);
    launch(1, 1);
    run(1 + (F + 3) + 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
